// File: rtl/mc_stage_sequencer.sv
// Sequences the five-stage multi-cycle CPU one instruction at a time, with redirect on exception/ERET,
// a per-stage watchdog, and a retired-instruction counter.
module mc_stage_sequencer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        run,
   input  logic        IF_over,
   input  logic        ID_over,
   input  logic        EXE_over,
   input  logic        MEM_over,
   input  logic        WB_over,
   input  logic        exception_triggered,
   input  logic        eret_executed,
   output logic        IF_valid,
   output logic        ID_valid,
   output logic        EXE_valid,
   output logic        MEM_valid,
   output logic        WB_valid,
   output logic        next_fetch,
   output logic        flush,
   output logic [31:0] retire_cnt,
   output logic        stage_timeout,
   output logic        timeout_flag,
   output logic [2:0]  timeout_stage,
   output logic [2:0]  cur_stage
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EXE  = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5
   } state_e;

   localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [WDW-1:0]   wd_q, wd_d;
   logic [31:0]      retire_q, retire_d;
   logic             tflag_q, tflag_d;
   logic [2:0]       tstage_q, tstage_d;

   logic active;
   logic stage_over;
   logic timeout_hit;
   logic redirect;
   logic fetch_raw;
   logic eret_retire;

   // Illegal codes 6/7 are not treated as active so they fall straight back to IDLE.
   assign active = (state_q >= S_IF) && (state_q <= S_WB);

   always_comb begin
      stage_over = 1'b0;
      case (state_q)
         S_IF:    stage_over = IF_over;
         S_ID:    stage_over = ID_over;
         S_EXE:   stage_over = EXE_over;
         S_MEM:   stage_over = MEM_over;
         S_WB:    stage_over = WB_over;
         default: stage_over = 1'b0;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && active && (wd_q == WD_LAST) && !stage_over;
   assign redirect    = active && (exception_triggered || eret_executed || timeout_hit);
   assign fetch_raw   = (state_q == S_WB) && WB_over && !exception_triggered
                        && !eret_executed && !timeout_hit;
   // An ERET coinciding with an exception is squashed by the exception.
   assign eret_retire = active && eret_executed && !exception_triggered;

   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = run ? S_IF : S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (run)      state_d = S_IF;
            S_IF:    if (IF_over)  state_d = S_ID;
            S_ID:    if (ID_over)  state_d = S_EXE;
            S_EXE:   if (EXE_over) state_d = S_MEM;
            S_MEM:   if (MEM_over) state_d = S_WB;
            S_WB:    if (WB_over)  state_d = run ? S_IF : S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      wd_d     = wd_q + WDW'(1);
      retire_d = retire_q;
      tflag_d  = tflag_q;
      tstage_d = tstage_q;
      // A redirect from IF back to IF restarts the stage, so it also restarts the watchdog.
      if (!active || redirect || (state_d != state_q)) wd_d = '0;
      if (fetch_raw || eret_retire) retire_d = retire_q + 32'd1;
      if (timeout_hit) begin
         tflag_d = 1'b1;
         if (!tflag_q) tstage_d = state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         wd_q     <= '0;
         retire_q <= 32'd0;
         tflag_q  <= 1'b0;
         tstage_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         retire_q <= retire_d;
         tflag_q  <= tflag_d;
         tstage_q <= tstage_d;
      end
   end

   assign IF_valid      = (state_q == S_IF);
   assign ID_valid      = (state_q == S_ID);
   assign EXE_valid     = (state_q == S_EXE);
   assign MEM_valid     = (state_q == S_MEM);
   assign WB_valid      = (state_q == S_WB);
   assign next_fetch    = resetn && fetch_raw;
   assign flush         = resetn && redirect;
   assign stage_timeout = resetn && timeout_hit;
   assign retire_cnt    = retire_q;
   assign timeout_flag  = tflag_q;
   assign timeout_stage = tstage_q;
   assign cur_stage     = state_q;

endmodule

// File: doc/mc_stage_sequencer.md
# mc_stage_sequencer

Control FSM that sequences the five-stage multi-cycle CPU (IF, ID, EXE, MEM, WB) one instruction at a time. It drives one stage-valid strobe per stage and the `next_fetch` strobe into the fetch stage. It restarts at IF on an exception or ERET, and recovers from hung stages with a watchdog. It sits at the top level beside the stage modules and also keeps a retired-instruction counter for the display logic.

## Interface

Parameters
- `TIMEOUT`, default 16: maximum number of cycles a stage may stay valid without reporting over. 0 disables the watchdog.

Ports
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `run` in 1: level. 1 lets instructions issue; 0 stops at the next instruction boundary.
- `IF_over`, `ID_over`, `EXE_over`, `MEM_over`, `WB_over` in 1 each: stage-complete indications from each stage.
- `exception_triggered` in 1: exception or interrupt taken, from the exception controller.
- `eret_executed` in 1: ERET executed, from decode.
- `IF_valid`, `ID_valid`, `EXE_valid`, `MEM_valid`, `WB_valid` out 1 each: stage-active strobes, exactly one or none high.
- `next_fetch` out 1: single-cycle strobe that lets fetch latch PC+4 or the branch target.
- `flush` out 1: single-cycle strobe telling stages to discard the in-flight instruction.
- `retire_cnt` out 32: count of retired instructions.
- `stage_timeout` out 1: single-cycle pulse when the watchdog fires.
- `timeout_flag` out 1: sticky watchdog flag.
- `timeout_stage` out 3: encoding of the stage that hung.
- `cur_stage` out 3: state encoding.

## Operation

State encoding
- IDLE=0, IF=1, ID=2, EXE=3, MEM=4, WB=5.
- Codes 6 and 7 are illegal and go to IDLE on the next cycle.

Valid outputs
- Each X_valid is a registered decode of the state: X_valid = (state==X).

Transitions, evaluated each cycle, highest priority first:
1. `!resetn`: go to IDLE.
2. state≠IDLE and (`exception_triggered` | `eret_executed` | `timeout_hit`): go to IF if `run`=1, else IDLE. Assert `flush`.
3. IDLE: go to IF if `run`=1.
4. IF→ID on `IF_over`; ID→EXE on `ID_over`; EXE→MEM on `EXE_over`; MEM→WB on `MEM_over`.
5. WB with `WB_over`: go to IF if `run`=1, else IDLE.
6. Otherwise hold state.

Strobe and counter rules
- `next_fetch` = `WB_valid` & `WB_over` & ~`exception_triggered` & ~`eret_executed` & ~`timeout_hit`. It is combinational. Redirects are handled by fetch itself, so `next_fetch` is suppressed during them.
- `flush` = (state≠IDLE) & (`exception_triggered` | `eret_executed` | `timeout_hit`). It is combinational.
- In IDLE, `exception_triggered` and `eret_executed` are ignored.
- `retire_cnt` increments by 1 on `next_fetch`, and on `eret_executed` when state≠IDLE. It does not increment on an exception or a timeout. It wraps from 0xFFFFFFFF to 0.

Watchdog
- `wd_cnt` is sized $clog2(TIMEOUT+1). It clears on every state change and in IDLE, and otherwise increments.
- `timeout_hit` = (TIMEOUT≠0) & (state≠IDLE) & (`wd_cnt`==TIMEOUT-1) & ~(current stage's over).
- On `timeout_hit`:
  - `stage_timeout` pulses for 1 cycle.
  - `timeout_flag` sets and stays set until reset.
  - `timeout_stage` captures the current state. Only the first timeout since reset is captured.

## Timing

Reset values
- state=IDLE, all X_valid=0, `retire_cnt`=0, `timeout_flag`=0, `timeout_stage`=0, `wd_cnt`=0.
- `next_fetch`, `flush` and `stage_timeout` are all 0 while `resetn`=0.

Latency
- First IF_valid comes 1 cycle after the first cycle with `resetn`=1 and `run`=1.
- With all over inputs tied high, an instruction takes 5 cycles (IF..WB), then IF again on the next cycle. This gives 1 instruction per 5 cycles.
- A stage whose over rises in cycle n: the next stage is valid in cycle n+1.
- Redirect seen in cycle n: IF_valid in cycle n+1. Fetch updates PC at the same edge.

Boundary conditions
- `WB_over` together with an exception: the exception wins, so no `next_fetch` and no retire.
- `exception_triggered` together with `eret_executed`: one flush, no retire.
- Over arriving in the same cycle that `wd_cnt` reaches TIMEOUT-1: no timeout, normal advance.
- `run` dropping mid-instruction: the instruction completes, then the FSM goes to IDLE after WB.
- `resetn` low mid-instruction: IDLE at the next edge, counters cleared.

## Test plan

1. Reset, then `run`=1 with all over=1 for 20 cycles → `cur_stage` cycles 1,2,3,4,5; `next_fetch` high in cycles 5,10,15,20; `retire_cnt`=4.
2. `EXE_over` delayed 3 cycles per instruction → EXE_valid held 3 cycles; no timeout; `retire_cnt` +1 per instruction.
3. `exception_triggered` pulsed during MEM → `flush`=1 in that cycle; IF_valid in the next cycle; `retire_cnt` unchanged; `next_fetch`=0.
4. `eret_executed` in ID, and separately `WB_over` together with `exception_triggered` → ERET: flush plus retire +1. WB case: flush, no `next_fetch`, no retire.
5. TIMEOUT=16 with `ID_over` stuck at 0 → `stage_timeout` pulses 16 cycles after ID entry; `timeout_flag`=1; `timeout_stage`=2; IF_valid in the next cycle.
6. `run` dropped during EXE, then `resetn` asserted during a later run → the FSM reaches IDLE after WB and stays there. After the mid-run reset: all outputs at their reset values, `retire_cnt`=0.
